// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer sample queues: sample width, queue
// geometry constants and the replay FSM state type.
package eq_pkg;

  localparam int SMPL_W      = 16;
  localparam int LF_DEPTH    = 1024;
  localparam int LF_READ_LEN = 1021;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } q_state_t;

endpackage : eq_pkg

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read that holds its last value whenever no read is issued.
module dual_port_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule : dual_port_ram

// File: rtl/low_freq_queue.sv
// Ring buffer ahead of the low-pass FIR: stores stereo samples and, on each new
// sample once full, replays the newest READ_LEN samples oldest-first.
module low_freq_queue
  import eq_pkg::*;
#(
  parameter int DEPTH    = LF_DEPTH,
  parameter int READ_LEN = LF_READ_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  input  logic              wrt_smpl,
  output logic [SMPL_W-1:0] lft_out,
  output logic [SMPL_W-1:0] rght_out,
  output logic              sequencing
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(READ_LEN + 1);

  q_state_t            state, next_state;
  logic [PTR_W-1:0]    new_ptr, old_ptr, rd_ptr;
  logic [CNT_W-1:0]    cnt, rd_cnt;
  logic                wrt_q, pending;
  logic                burst_req, last_rd, rd_en;
  logic [2*SMPL_W-1:0] rd_data;

  // The request is taken from the registered strobe so cnt already reflects the write.
  assign burst_req = wrt_q && (cnt == CNT_W'(READ_LEN));
  assign rd_en     = (state == READ);
  assign last_rd   = rd_en && (rd_cnt == CNT_W'(READ_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      cnt     <= '0;
      wrt_q   <= 1'b0;
    end else begin
      wrt_q <= wrt_smpl;
      if (wrt_smpl) begin
        new_ptr <= new_ptr + PTR_W'(1);
        if (cnt != CNT_W'(READ_LEN)) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (burst_req) next_state = READ;
      READ:    if (last_rd && !(pending || burst_req)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A request seen mid-burst is held in pending; a burst ending with a request
  // outstanding restarts directly from the advanced window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      old_ptr <= '0;
      rd_ptr  <= '0;
      rd_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (burst_req) begin
            rd_ptr <= old_ptr;
            rd_cnt <= '0;
          end
        end
        READ: begin
          if (last_rd) begin
            old_ptr <= old_ptr + PTR_W'(1);
            rd_ptr  <= old_ptr + PTR_W'(1);
            rd_cnt  <= '0;
            pending <= 1'b0;
          end else begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (burst_req) pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sequencing <= 1'b0;
    else        sequencing <= rd_en;
  end

  dual_port_ram #(
    .WIDTH (2 * SMPL_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wrt_smpl),
    .wr_addr (new_ptr),
    .wr_data ({lft_smpl, rght_smpl}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign lft_out  = rd_data[2*SMPL_W-1:SMPL_W];
  assign rght_out = rd_data[SMPL_W-1:0];

endmodule : low_freq_queue

// File: tb/tb_low_freq_queue.sv
// Directed self-checking bench for low_freq_queue: sample k is written as
// left=k, right=-k so every replayed window has hand-computable contents.
module tb_low_freq_queue;
  import eq_pkg::*;

  localparam int RL = LF_READ_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lft_smpl = '0;
  logic [15:0] rght_smpl = '0;
  logic        wrt_smpl = 1'b0;
  logic [15:0] lft_out, rght_out;
  logic        sequencing;

  int checks = 0;
  int errors = 0;
  int seqSeen = 0;

  low_freq_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .wrt_smpl   (wrt_smpl),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle strobe of sample k; called and returning on a falling edge.
  task automatic applyStimulus(input int k);
    lft_smpl  = 16'(k);
    rght_smpl = 16'(-k);
    wrt_smpl  = 1'b1;
    @(negedge clk);
    wrt_smpl  = 1'b0;
    if (sequencing) seqSeen++;
  endtask

  // Expected stream: firstA.. for the first RL beats, then firstB.. for a
  // chained second burst. Optional strobes are issued at given burst beats.
  task automatic checkBurst(input string tag, input int firstA, input int firstB,
                            input int expLen, input int strobeA, input int valA,
                            input int strobeB, input int valB);
    int lat = 0;
    int n = 0;
    int errs = 0;
    int firstL = 0;
    int firstR = 0;
    int expv;
    while (!sequencing && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 2);
    while (sequencing && n < 4000) begin
      expv = (n < RL) ? firstA + n : firstB + n - RL;
      if (n == 0) begin
        firstL = int'($signed(lft_out));
        firstR = int'($signed(rght_out));
      end
      if (int'($signed(lft_out)) != expv || int'($signed(rght_out)) != -expv) errs++;
      n++;
      wrt_smpl = 1'b0;
      if (n == strobeA || n == strobeB) begin
        lft_smpl  = 16'((n == strobeA) ? valA : valB);
        rght_smpl = 16'(-((n == strobeA) ? valA : valB));
        wrt_smpl  = 1'b1;
      end
      @(negedge clk);
    end
    wrt_smpl = 1'b0;
    checkOutput({tag, "_first_left"}, firstL, firstA);
    checkOutput({tag, "_first_right"}, firstR, -firstA);
    checkOutput({tag, "_data_errs"}, errs, 0);
    checkOutput({tag, "_len"}, n, expLen);
  endtask

  initial begin
    int waitCnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_seq", int'(sequencing), 0);
    checkOutput("reset_lft", int'(lft_out), 0);
    checkOutput("reset_rght", int'(rght_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Partial fill, then reset: the count must restart from zero.
    for (int i = 0; i < 500; i++) applyStimulus(5000 + i);
    rst_n = 1'b0;
    #1;
    checkOutput("midfill_rst_seq", int'(sequencing), 0);
    checkOutput("midfill_rst_lft", int'(lft_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    seqSeen = 0;
    for (int k = 1; k <= RL - 1; k++) applyStimulus(k);
    repeat (4) begin
      @(negedge clk);
      if (sequencing) seqSeen++;
    end
    checkOutput("fill_no_burst", seqSeen, 0);

    applyStimulus(RL);
    checkBurst("fill", 1, 0, RL, -1, 0, -1, 0);

    applyStimulus(1022);
    checkBurst("steady", 2, 0, RL, -1, 0, -1, 0);

    // Samples 1024 and 1025 sit at addresses 1023 and 0.
    for (int k = 1023; k <= 1028; k++) begin
      applyStimulus(k);
      checkBurst("wrap", k - 1020, 0, RL, -1, 0, -1, 0);
    end

    // Strobe at beat 500 chains a second burst; strobe at beat 700 is an overrun.
    applyStimulus(1029);
    checkBurst("overlap", 9, 10, 2 * RL, 500, 1030, 700, 1031);
    checkOutput("overlap_idle_after", int'(sequencing), 0);

    applyStimulus(1032);
    checkBurst("post_overrun", 11, 0, RL, -1, 0, -1, 0);
    applyStimulus(1033);
    checkBurst("post_overrun2", 12, 0, RL, -1, 0, -1, 0);

    // Reset 300 beats into a burst.
    applyStimulus(1034);
    waitCnt = 0;
    while (!sequencing && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midburst_start", int'(sequencing), 1);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midburst_rst_seq", int'(sequencing), 0);
    checkOutput("midburst_rst_lft", int'(lft_out), 0);
    checkOutput("midburst_rst_rght", int'(rght_out), 0);
    checkOutput("midburst_rst_state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    seqSeen = 0;
    applyStimulus(2000);
    repeat (1100) begin
      @(negedge clk);
      if (sequencing) seqSeen++;
    end
    checkOutput("post_rst_no_burst", seqSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_low_freq_queue

// File: doc/low_freq_queue.md
Name: low_freq_queue

Overview:
- Circular sample queue directly upstream of the low-pass FIR stage.
- Stores incoming stereo audio samples in a ring buffer.
- On each new sample, once READ_LEN samples are held, replays the most recent READ_LEN samples oldest-first, one per clock.
- Asserts sequencing for exactly READ_LEN cycles, aligned with valid output data, so the FIR coefficient counter and accumulator step in lockstep.

Parameters:
- DEPTH, 1024: ring entries per channel; power of two; pointers wrap naturally at log2(DEPTH) bits.
- READ_LEN, 1021: samples replayed per burst, equal to FIR tap count; must satisfy READ_LEN <= DEPTH-2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- lft_smpl  input  16  signed left sample in.
- rght_smpl  input  16  signed right sample in.
- wrt_smpl  input  1  one-cycle strobe; sample valid this cycle.
- lft_out  output  16  signed left replayed sample.
- rght_out  output  16  signed right replayed sample.
- sequencing  output  1  high while lft_out/rght_out carry burst data.

Behaviour:
- Reset:
  - new_ptr=0, old_ptr=0, cnt=0, rd_ptr=0.
  - State IDLE, pending=0.
  - sequencing=0, lft_out=0, rght_out=0.
  - Reset mid-burst aborts the burst immediately; RAM contents are don't-care afterwards.
- Write:
  - On wrt_smpl at edge T, both channels are written at new_ptr and new_ptr increments (mod DEPTH).
  - cnt increments, saturating at READ_LEN.
- Fill phase (cnt < READ_LEN after the write): no burst; sequencing stays 0.
- Burst trigger: a write after which cnt == READ_LEN (the first fill or any later write) requests a burst.
- FSM states and transitions:
  - IDLE -> READ on request. Latch rd_ptr=old_ptr.
  - READ: issue RAM read address rd_ptr for READ_LEN consecutive cycles (T+1 .. T+READ_LEN), incrementing rd_ptr mod DEPTH.
  - READ -> IDLE after the last address. At that point old_ptr increments by 1.
- RAM timing and output alignment:
  - RAM read latency is 1 cycle, so data is valid at T+2 .. T+READ_LEN+1.
  - sequencing is registered and high exactly on those READ_LEN cycles; the first output is the oldest held sample.
  - While sequencing=0, lft_out/rght_out hold their last value.
- Window: each burst covers old_ptr .. old_ptr+READ_LEN-1 mod DEPTH, i.e. the newest READ_LEN samples including the one just written.
- wrt_smpl during a burst:
  - The sample is still written (slack of DEPTH-READ_LEN entries prevents overwriting unread data for 1 pending sample).
  - pending is set; when the burst ends, the FSM returns to READ without an IDLE cycle, with sequencing continuous.
  - A second strobe while pending=1 is written but does not queue another burst (documented overrun).
- Simultaneous burst end and wrt_smpl: treated as pending; back-to-back burst.
- Pointer wrap: all pointer arithmetic is mod DEPTH; no special case at DEPTH-1 -> 0.
- No arithmetic on sample data; samples pass through bit-exact.

Decomposition:
- Shared package eq_pkg:
  - SMPL_W=16.
  - State enum typedef q_state_t {IDLE, READ}.
  - LF_DEPTH/LF_READ_LEN constants, reused by a future high-frequency queue instance with different values.
- Sub-module dual_port_ram:
  - One write port and one read port, 1-cycle registered read.
  - Width 32 (left and right concatenated), depth DEPTH.
- Control FSM, pointers and counters live in low_freq_queue.

Test Plan:
- Reset: assert rst_n=0 mid-fill -> sequencing=0, lft_out=rght_out=0, and next 1020 strobes produce no burst.
- Fill: write samples 1..1021 (left=k, right=-k) -> first sequencing begins 2 cycles after 1021st strobe, lasts 1021 cycles, left outputs 1,2,...,1021 in order.
- Steady state: write sample 1022 after burst -> burst outputs 2..1022; sequencing low for exactly 1 cycle between bursts is not required; check count=1021.
- Wrap: write 3000 samples, spacing >READ_LEN+2 cycles -> every burst outputs the last 1021 values in order across pointer wrap at 1023->0.
- Overlap: strobe at burst cycle 500 -> second burst follows with no sequencing gap, window advanced by 1; a third strobe in the same burst queues nothing.
- Reset mid-burst at cycle 300 -> sequencing drops on the reset assertion, outputs are 0, and the FSM is IDLE.
